// File: rtl/pipe_pkg.sv
// Shared parameter set for pipe_stage_reg in its MEM/WB role:
// lane map, control bit positions and default widths.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_CNT_W  = 16;

  localparam int MEMWB_LANES  = 3;
  localparam int MEMWB_CTRL_W = 2;

  localparam int LANE_MEM = 0;
  localparam int LANE_ALU = 1;
  localparam int LANE_MUX = 2;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used to count stalled cycles of a pipeline stage.
// Holds at all-ones once reached; only clear or reset bring it back to zero.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush,
// bubble gating of control bits and a saturating stall counter.
// Build option: PIPE_SKID_EN adds a skid register so that in_ready is a
// flop output with no combinational path from out_ready. Without it, the
// stage is a single register with in_ready = !out_valid || out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = MEMWB_LANES,
  parameter int CTRL_W = MEMWB_CTRL_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [REG_W-1:0]        in_rd,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [REG_W-1:0]        out_rd,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int PW = LANES * DATA_W;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [REG_W-1:0]  main_rd_q, main_rd_d;
  logic [PW-1:0]     main_data_q, main_data_d;

  logic take_in;
  logic drain;

  assign take_in = in_valid && in_ready;
  assign drain   = main_valid_q && out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [REG_W-1:0]  skid_rd_q, skid_rd_d;
  logic [PW-1:0]     skid_data_q, skid_data_d;

  // Skid occupancy is itself a flop, so in_ready carries no path from out_ready.
  assign in_ready = !skid_valid_q;

  // Main/skid steering: when main frees up it takes skid first, then input;
  // input arriving while main is stuck lands in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_rd_d    = main_rd_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_rd_d    = skid_rd_q;
        main_data_d  = skid_data_q;
        skid_valid_d = take_in;
        if (take_in) begin
          skid_ctrl_d = in_ctrl;
          skid_rd_d   = in_rd;
          skid_data_d = in_data;
        end
      end else if (take_in) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_rd_d    = in_rd;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (take_in) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_rd_d    = in_rd;
      skid_data_d  = in_data;
    end
  end

  // Skid register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Single register: accept when empty or emptying this cycle.
  assign in_ready = !main_valid_q || out_ready;

  // Load on accept, empty on drain; flush drops both held and offered entries.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_rd_d    = main_rd_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (take_in) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_rd_d    = in_rd;
      main_data_d  = in_data;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  // Main register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_rd_q    <= '0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_rd_q    <= main_rd_d;
      main_data_q  <= main_data_d;
    end
  end

  // A bubble must never present live control bits (e.g. RegWrite).
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_rd    = main_rd_q;
  assign out_data  = main_data_q;

  // Stall count survives flush; only reset clears it.
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .inc   (main_valid_q && !out_ready),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [1:0]  in_ctrl, out_ctrl;
  logic [4:0]  in_rd, out_rd;
  logic [95:0] in_data, out_data;
  logic [15:0] stall_cnt;

  logic        s_flush, s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [1:0]  s_out_ctrl;
  logic [4:0]  s_out_rd;
  logic [95:0] s_out_data;
  logic [3:0]  s_stall_cnt;

  always #5 Clk = ~Clk;

  pipe_stage_reg u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .Clk(Clk), .Rst_n(Rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(2'b11), .in_rd(5'd1), .in_data(96'h1),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ctrl(s_out_ctrl), .out_rd(s_out_rd), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic [95:0] data;
  } ent_t;

  typedef struct {
    logic       iv, ordy, fl;
    logic [1:0] ctrl;
    logic [4:0] rd;
    logic       rdy, ov;
    logic [1:0] octrl;
    logic [4:0] ord;
  } vec_t;

  ent_t        sb[$];
  vec_t        vecs[10];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out = 0;
  logic        m_valid;
  ent_t        m_ent;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] mk_data(input logic [4:0] rd);
    logic [31:0] l;
    l = 32'(rd) * 32'h01010101;
    return {l, ~l, l ^ 32'h5a5a5a5a};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ent   = '0;
    m_cnt   = '0;
    sb.delete();
  endtask

  // One clock: check outputs against the reference model mid-cycle, settle
  // transfers, then advance the model at the rising edge.
  task automatic cycle();
    logic tin, tout;
    ent_t e;
    @(negedge Clk);
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("out_ctrl", out_ctrl, m_valid ? m_ent.ctrl : 2'b00);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (m_valid) begin
      chk("out_rd", out_rd, m_ent.rd);
      chk("out_data", out_data, m_ent.data);
    end
    tin  = in_valid && (!m_valid || out_ready);
    tout = m_valid && out_ready;
    if (tout) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("sb_nonempty", 1'b0, 1'b1);
      end else begin
        e = sb.pop_front();
        chk("sb_entry", {out_ctrl, out_rd, out_data}, e);
      end
    end
    @(posedge Clk);
    if (m_valid && !out_ready && m_cnt != 16'hffff) m_cnt++;
    if (flush) begin
      m_valid = 1'b0;
      sb.delete();
    end else if (tin) begin
      m_valid = 1'b1;
      m_ent   = '{ctrl: in_ctrl, rd: in_rd, data: in_data};
      sb.push_back(m_ent);
    end else if (tout) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [1:0] c, input logic [4:0] r);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_ctrl   = c;
    in_rd     = r;
    in_data   = mk_data(r);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_ctrl"}, out_ctrl, 2'b00);
    chk({tag, "_out_rd"}, out_rd, 5'd0);
    chk({tag, "_out_data"}, out_data, 96'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 16'd0);
  endtask

  initial begin
    int   out0;
    logic [15:0] cnt0;

    // iv ordy fl ctrl rd | rdy ov octrl ord
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'b01, 5'd3, 1'b1, 1'b1, 2'b01, 5'd3};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 2'b11, 5'd7, 1'b1, 1'b0, 2'b00, 5'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'b11, 5'd4, 1'b1, 1'b1, 2'b11, 5'd4};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'b01, 5'd5, 1'b0, 1'b1, 2'b11, 5'd4};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2'b01, 5'd5, 1'b1, 1'b1, 2'b01, 5'd5};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b10, 5'd6, 1'b0, 1'b0, 2'b00, 5'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 2'b10, 5'd6, 1'b1, 1'b0, 2'b00, 5'd0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 2'b00, 5'd0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 2'b10, 5'd8, 1'b1, 1'b1, 2'b10, 5'd8};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 1'b1, 1'b0, 2'b00, 5'd0};

    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    model_reset();
    #12;
    check_all_zero("rst");
    chk("rst_s_stall_cnt", s_stall_cnt, 4'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);

    // Directed vectors: bubble gating, stall, replace-on-drain, flush.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, vecs[i].rd);
      #2;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      cycle();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, vecs[i].octrl);
      if (vecs[i].ov) chk($sformatf("vec%0d_out_rd", i), out_rd, vecs[i].ord);
    end

    // Streaming 100 entries with fixed MEM/WB payload.
    out0 = n_out;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    in_ctrl = 2'b01; in_rd = 5'd9;
    in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    repeat (100) cycle();
    in_valid = 1'b0;
    cycle();
    chk("stream_count", n_out - out0, 100);

    // Random handshake traffic.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    cycle();

    // Back-pressure: 4 stalled cycles with input still offered.
    drive(1'b1, 1'b1, 1'b0, 2'b01, 5'd12);
    cycle();
    cnt0 = m_cnt;
    drive(1'b1, 1'b0, 1'b0, 2'b11, 5'd13);
    repeat (4) cycle();
    chk("bp_stall_cnt", stall_cnt, cnt0 + 16'd4);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_rd", out_rd, 5'd12);
    chk("bp_out_data", out_data, mk_data(5'd12));
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("bp_drained", out_valid, 1'b0);

    // Flush while full with an input offered.
    drive(1'b1, 1'b1, 1'b0, 2'b01, 5'd20);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 2'b11, 5'd21);
    cycle();
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_out_ctrl", out_ctrl, 2'b00);
    drive(1'b0, 1'b1, 1'b0, 2'b11, 5'd0);
    repeat (3) cycle();

    // Reset asserted mid-stall.
    drive(1'b1, 1'b1, 1'b0, 2'b01, 5'd25);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 5'd26);
    repeat (2) cycle();
    #3;
    Rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    cycle();

    // Saturation on the 4-bit counter instance.
    s_in_valid = 1'b1; s_out_ready = 1'b0;
    repeat (11) begin @(posedge Clk); #1; end
    chk("sat_mid", s_stall_cnt, 4'd10);
    repeat (10) begin @(posedge Clk); #1; end
    chk("sat_full", s_stall_cnt, 4'd15);
    chk("sat_ctrl_valid", s_out_ctrl, 2'b11);
    s_flush = 1'b1;
    @(posedge Clk); #1;
    s_flush = 1'b0; s_in_valid = 1'b0;
    chk("sat_flush_valid", s_out_valid, 1'b0);
    chk("sat_flush_ctrl", s_out_ctrl, 2'b00);
    chk("sat_after_flush", s_stall_cnt, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register. It generalises the fixed MEM/WB latch into a reusable stage with a valid/ready handshake, flush, bubble gating of control bits and a saturating stall counter. The block sits between any two pipeline stages of the datapath; its first use is MEM→WB, carrying the memory read data, the ALU result, the mux result, the write-register index and the RegWrite/MemtoReg controls.

## Interface
- DATA_W, 32, width of one data lane
- LANES, 3, number of data lanes carried (MEM/WB: readMem, ALUResult, muxResult)
- CTRL_W, 2, control bits carried (MEM/WB: bit0 RegWrite, bit1 MemtoReg)
- REG_W, 5, destination register index width
- CNT_W, 16, stall counter width

- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries and any entry accepted this cycle
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  control bits
- in_rd  in  REG_W  destination register
- in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control bits, forced 0 when out_valid=0
- out_rd  out  REG_W  destination register
- out_data  out  LANES*DATA_W  lane data
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Main register (valid bit plus payload) loads on a transfer in when it is empty or draining in the same cycle. Otherwise it holds.
- Bubble gating: out_ctrl = out_valid ? ctrl_q : 0, so a bubble can never assert RegWrite. out_rd and out_data hold their last value while invalid.
- flush has priority over everything: all valid bits are 0 after the edge and any input offered in that cycle is dropped. Payload registers need not clear.
- Stall counter: increments on each edge where out_valid && !out_ready. It saturates at 2^CNT_W−1. Only reset clears it, not flush.
- Arithmetic: the counter is unsigned. No arithmetic is applied to the payload.

## Timing
- Reset (Rst_n=0, asynchronous): out_valid=0, out_ctrl=0, out_rd=0, out_data=0, stall_cnt=0, all valid bits 0. in_ready=1 in the first cycle after reset.
- Latency: 1 cycle from transfer in to out_valid.
- Throughput: 1 entry per cycle while out_ready=1.
- Without skid: in_ready = !out_valid || out_ready. This is combinational from out_ready.
- Full (out_valid && !out_ready): in_ready=0 and the payload is stable. Downstream may change out_ready at any time, and data never changes while out_valid && !out_ready.
- Simultaneous transfer in and out: the new entry replaces the old one and out_valid stays 1.
- Reset asserted mid-stall: all contents are lost immediately.

## Configuration
- PIPE_SKID_EN defined: a second (skid) register is added, and in_ready becomes a registered signal equal to !skid_valid, with no combinational path from out_ready.
  - An input accepted while the main register is full and not draining goes to skid.
  - When main drains, skid moves to main.
  - Capacity is 2 and throughput stays 1/cycle.
  - Flush clears both valid bits.
- PIPE_SKID_EN undefined: a single register with the combinational in_ready described above.

## Structure
- Package pipe_pkg holds the MEM/WB parameter set: MEMWB_LANES=3, lane index constants LANE_MEM=0, LANE_ALU=1 and LANE_MUX=2, control bit indices CTRL_REGWRITE=0 and CTRL_MEMTOREG=1, and the default DATA_W, REG_W and CNT_W.
- One sub-module is natural: pipe_sat_counter, for the stall counter (parameter CNT_W; inputs inc and clear).
- Everything else stays in one module.

## Test plan
- Reset: assert Rst_n=0 mid-cycle → every output is 0 immediately; after release, in_ready=1 and out_valid=0.
- Streaming: out_ready=1, with lanes 0x11111111, 0x22222222 and 0x33333333, ctrl=2'b01 and rd=5'd9 offered each cycle → the same values appear one cycle later, with no gaps over 100 entries.
- Back-pressure: hold out_ready=0 for 4 cycles with in_valid=1 → the output is stable, stall_cnt=4 and the entry is neither lost nor duplicated. Without skid, in_ready=0 during the stall. With PIPE_SKID_EN, exactly one extra entry is accepted, then in_ready=0.
- Flush: flush=1 while full and while in_valid=1 → out_valid=0 and out_ctrl=0 on the next cycle, and the dropped input never appears.
- Bubble gating: in_valid=0 with in_ctrl=2'b11 → out_ctrl stays 2'b00.
- Saturation: with CNT_W=4, stall for 20 cycles → stall_cnt=15; flush does not change it.
